// File: rtl/test_dac_driver.sv
// Free-running ramp generator for a 16-bit SYNC/SCLK/DIN DAC with a 24-bit frame.
// Define TEST_DAC_TRIANGLE_EN to make the code ramp up and down instead of wrapping.
module test_dac_driver #(
  parameter int          CLK_DIV   = 2,
  parameter int          GAP_TICKS = 4,
  parameter logic [15:0] STEP      = 16'd1,
  parameter logic [1:0]  PD_BITS   = 2'b00
) (
  input  logic clk,
  input  logic reset,
  output logic clk_out,
  output logic sync_out,
  output logic din
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

  typedef enum logic {S_GAP, S_SHIFT} state_t;

  state_t           r_state, w_state_next;
  logic [DIV_W-1:0] r_div, w_div_next;
  logic [GAP_W-1:0] r_gap, w_gap_next;
  logic [4:0]       r_idx, w_idx_next;
  logic [23:0]      r_shift, w_shift_next;
  logic [15:0]      r_code, w_code_next, w_code_adv;
  logic             r_sclk, w_sclk_next;
  logic             r_sync, w_sync_next;
  logic             r_din, w_din_next;
  logic             w_tick;
  logic [23:0]      w_frame;

  assign w_tick     = (r_div == DIV_LAST);
  assign w_div_next = w_tick ? '0 : r_div + 1'b1;
  assign w_frame    = {6'b0, PD_BITS, r_code};

`ifdef TEST_DAC_TRIANGLE_EN
  // r_dir: 0 = counting up, 1 = counting down
  logic r_dir, w_dir_next, w_dir_adv;

  always_comb begin
    w_code_adv = r_code;
    w_dir_adv  = r_dir;
    if (!r_dir) begin
      if (r_code >= 16'hFFFF - STEP) begin
        w_code_adv = 16'hFFFF;
        w_dir_adv  = 1'b1;
      end else begin
        w_code_adv = r_code + STEP;
      end
    end else if (r_code <= STEP) begin
      w_code_adv = 16'h0000;
      w_dir_adv  = 1'b0;
    end else begin
      w_code_adv = r_code - STEP;
    end
  end
`else
  assign w_code_adv = r_code + STEP;
`endif

  always_comb begin
    w_state_next = r_state;
    w_gap_next   = r_gap;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_code_next  = r_code;
    w_sclk_next  = r_sclk;
    w_sync_next  = r_sync;
    w_din_next   = r_din;
`ifdef TEST_DAC_TRIANGLE_EN
    w_dir_next   = r_dir;
`endif
    if (w_tick) begin
      unique case (r_state)
        S_GAP: begin
          w_sclk_next = 1'b1;
          if (r_gap == GAP_LAST) begin
            // Latch the whole word so the code update cannot disturb this frame
            w_shift_next = w_frame;
            w_din_next   = w_frame[23];
            w_idx_next   = 5'd23;
            w_gap_next   = '0;
            w_sync_next  = 1'b0;
            w_state_next = S_SHIFT;
          end else begin
            w_gap_next = r_gap + 1'b1;
          end
        end
        S_SHIFT: begin
          w_sclk_next = ~r_sclk;
          if (!r_sclk) begin
            if (r_idx != 5'd0) begin
              w_idx_next = r_idx - 5'd1;
              w_din_next = r_shift[r_idx - 5'd1];
            end else begin
              w_sync_next  = 1'b1;
              w_din_next   = 1'b0;
              w_code_next  = w_code_adv;
`ifdef TEST_DAC_TRIANGLE_EN
              w_dir_next   = w_dir_adv;
`endif
              w_state_next = S_GAP;
            end
          end
        end
        default: w_state_next = S_GAP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_GAP;
      r_div   <= '0;
      r_gap   <= '0;
      r_idx   <= 5'd23;
      r_shift <= '0;
      r_code  <= '0;
      r_sclk  <= 1'b1;
      r_sync  <= 1'b1;
      r_din   <= 1'b0;
`ifdef TEST_DAC_TRIANGLE_EN
      r_dir   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_div   <= w_div_next;
      r_gap   <= w_gap_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_code  <= w_code_next;
      r_sclk  <= w_sclk_next;
      r_sync  <= w_sync_next;
      r_din   <= w_din_next;
`ifdef TEST_DAC_TRIANGLE_EN
      r_dir   <= w_dir_next;
`endif
    end
  end

  assign clk_out  = r_sclk;
  assign sync_out = r_sync;
  assign din      = r_din;

endmodule

// File: tb/tb_test_dac_driver.sv
// Directed bench for test_dac_driver: three instances (defaults, STEP=0x1000 with PD=11,
// STEP=0x4000) are decoded from their pins and compared against hand-computed words.
`timescale 1ns/1ps
module tb_test_dac_driver;
  logic clk;
  logic rst_n;
  logic sclk [3];
  logic sync [3];
  logic dout [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

`ifdef TEST_DAC_TRIANGLE_EN
  localparam logic [15:0] EXP_B [17] = '{16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h4000,
                                         16'h5000, 16'h6000, 16'h7000, 16'h8000, 16'h9000,
                                         16'hA000, 16'hB000, 16'hC000, 16'hD000, 16'hE000,
                                         16'hF000, 16'hFFFF};
  localparam logic [15:0] EXP_C [10] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF,
                                         16'hBFFF, 16'h7FFF, 16'h3FFF, 16'h0000, 16'h4000};
`else
  localparam logic [15:0] EXP_B [17] = '{16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h4000,
                                         16'h5000, 16'h6000, 16'h7000, 16'h8000, 16'h9000,
                                         16'hA000, 16'hB000, 16'hC000, 16'hD000, 16'hE000,
                                         16'hF000, 16'h0000};
  localparam logic [15:0] EXP_C [10] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000,
                                         16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h4000};
`endif

  test_dac_driver u_dut_a (
    .clk(clk), .reset(rst_n), .clk_out(sclk[0]), .sync_out(sync[0]), .din(dout[0])
  );
  test_dac_driver #(.STEP(16'h1000), .PD_BITS(2'b11)) u_dut_b (
    .clk(clk), .reset(rst_n), .clk_out(sclk[1]), .sync_out(sync[1]), .din(dout[1])
  );
  test_dac_driver #(.STEP(16'h4000)) u_dut_c (
    .clk(clk), .reset(rst_n), .clk_out(sclk[2]), .sync_out(sync[2]), .din(dout[2])
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pin-level frame decoder, sampled on the clk falling edge
  logic        prev_sclk [3];
  logic        prev_sync [3];
  logic        prev_din  [3];
  logic [23:0] acc       [3];
  int          nfall     [3] = '{0, 0, 0};
  int          nfr       [3] = '{0, 0, 0};
  int          unstable  [3] = '{0, 0, 0};
  logic [23:0] word_log  [3][32];
  int          fall_log  [3][32];
  logic        rise_log  [3][32];
  int          start_cyc [3][32];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      prev_sclk[k] <= sclk[k];
      prev_sync[k] <= sync[k];
      prev_din[k]  <= dout[k];
      if (!rst_n) begin
        acc[k]   <= '0;
        nfall[k] <= 0;
      end else begin
        if (prev_sync[k] && !sync[k]) begin
          acc[k]   <= '0;
          nfall[k] <= 0;
          if (nfr[k] < 32) start_cyc[k][nfr[k]] <= cyc;
        end
        if (prev_sclk[k] && !sclk[k] && !sync[k]) begin
          acc[k]   <= {acc[k][22:0], dout[k]};
          nfall[k] <= nfall[k] + 1;
          if (dout[k] != prev_din[k]) unstable[k] <= unstable[k] + 1;
        end
        if (!prev_sync[k] && sync[k]) begin
          if (nfr[k] < 32) begin
            word_log[k][nfr[k]] <= acc[k];
            fall_log[k][nfr[k]] <= nfall[k];
            rise_log[k][nfr[k]] <= sclk[k] && !prev_sclk[k];
          end
          nfr[k] <= nfr[k] + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[%0t] FAIL %s: got 0x%0h expected 0x%0h", $time, tag, got, exp);
    end else begin
      $display("[%0t] ok   %s: 0x%0h", $time, tag, got);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  edge_n;
    int  base;
    bit  done;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk_out", 32'(sclk[0]), 32'd1);
    check("rst_sync_out", 32'(sync[0]), 32'd1);
    check("rst_din", 32'(dout[0]), 32'd0);

    rst_n  = 1'b1;
    edge_n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (!sync[0]) begin edge_n = i; break; end
    end
    check("sync_fall_edge", 32'(edge_n), 32'd8);

    done = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      if (nfr[0] >= 3 && nfr[1] >= 17 && nfr[2] >= 10) begin done = 1; break; end
    end
    check("frames_done", 32'(done), 32'd1);

    for (int i = 0; i < 3; i++) begin
      check($sformatf("a_word%0d", i), 32'(word_log[0][i]), 32'(i));
      check($sformatf("a_falls%0d", i), 32'(fall_log[0][i]), 32'd24);
    end
    check("a_rise_with_sync", 32'(rise_log[0][0]), 32'd1);
    check("a_spacing01", 32'(start_cyc[0][1] - start_cyc[0][0]), 32'd104);
    check("a_spacing12", 32'(start_cyc[0][2] - start_cyc[0][1]), 32'd104);
    check("din_unstable", 32'(unstable[0] + unstable[1] + unstable[2]), 32'd0);

    check("b_first_word", 32'(word_log[1][0]), 32'h030000);
    check("b_falls0", 32'(fall_log[1][0]), 32'd24);
    for (int i = 0; i < 17; i++)
      check($sformatf("b_word%0d", i), 32'(word_log[1][i]), 32'({8'h03, EXP_B[i]}));
    for (int i = 0; i < 10; i++)
      check($sformatf("c_word%0d", i), 32'(word_log[2][i]), 32'({8'h00, EXP_C[i]}));

    // Abort a frame while bit 10 is on the wire (clk_out low after its falling edge)
    done = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (!sync[0] && nfall[0] == 14) begin done = 1; break; end
    end
    check("bit10_found", 32'(done), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_sync_out", 32'(sync[0]), 32'd1);
    check("abort_clk_out", 32'(sclk[0]), 32'd1);
    check("abort_din", 32'(dout[0]), 32'd0);

    repeat (3) @(negedge clk);
    base   = nfr[0];
    rst_n  = 1'b1;
    edge_n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (!sync[0]) begin edge_n = i; break; end
    end
    check("resync_fall_edge", 32'(edge_n), 32'd8);

    done = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (nfr[0] > base) begin done = 1; break; end
    end
    check("post_reset_done", 32'(done), 32'd1);
    check("post_reset_word", 32'(word_log[0][base]), 32'h000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
